// File: rtl/i2c_passthru_bus_recovery.sv
// I2C bus-clear sequencer: clocks SCL until the target releases SDA, issues a STOP,
// then waits for the idle detector to confirm the bus is free again.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a stuck rising edge while enabled
// LOW     | recovery pulse, SCL pulled low
// HIGH    | SCL released; wait out stretch, then time the high phase
// STOP_A  | SCL low, SDA pulled low one cycle after SCL (no false START)
// STOP_B  | SCL released, SDA still low; same high-phase timing as HIGH
// STOP_C  | SDA released with SCL high (STOP); wait for bus idle
// DONE    | one-cycle done pulse
// FAIL    | recovery failed; held until stuck clears
// REARM   | wait for stuck to clear before accepting a new attempt
module i2c_passthru_bus_recovery #(
  parameter int F_REF_T_LOW         = 20,
  parameter int F_REF_T_HIGH        = 20,
  parameter int NUM_PULSES          = 9,
  parameter int F_REF_T_STRETCH_MAX = 200,
  parameter int F_REF_T_IDLE_WAIT   = 250,
  parameter int WIDTH_CNT           = 8
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_f_ref,
  input  logic i_en,
  input  logic i_stuck,
  input  logic i_idle,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_pull,
  output logic o_sda_pull,
  output logic o_busy,
  output logic o_done,
  output logic o_fail
);

  localparam int PW = $clog2(NUM_PULSES + 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOW    = 4'd1;
  localparam logic [3:0] S_HIGH   = 4'd2;
  localparam logic [3:0] S_STOP_A = 4'd3;
  localparam logic [3:0] S_STOP_B = 4'd4;
  localparam logic [3:0] S_STOP_C = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
  localparam logic [3:0] S_FAIL   = 4'd7;
  localparam logic [3:0] S_REARM  = 4'd8;

  localparam logic [WIDTH_CNT-1:0] T_LOW  = WIDTH_CNT'(F_REF_T_LOW);
  localparam logic [WIDTH_CNT-1:0] T_HIGH = WIDTH_CNT'(F_REF_T_HIGH);
  localparam logic [WIDTH_CNT-1:0] T_STR  = WIDTH_CNT'(F_REF_T_STRETCH_MAX);
  localparam logic [WIDTH_CNT-1:0] T_IDLE = WIDTH_CNT'(F_REF_T_IDLE_WAIT);
  localparam logic [WIDTH_CNT-1:0] CNT_ONE = WIDTH_CNT'(1);
  localparam logic [PW-1:0]        PULSES  = PW'(NUM_PULSES);

  logic [3:0]           state_q, state_d;
  logic [WIDTH_CNT-1:0] cnt_q, cnt_d;
  logic [WIDTH_CNT-1:0] str_q, str_d;
  logic [PW-1:0]        pcnt_q, pcnt_d;
  logic                 f_ref_q, stuck_q;
  logic                 scl_pull_q, scl_pull_d;
  logic                 sda_pull_q, sda_pull_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic                 tick, stuck_rise, busy_state;

  always_comb begin
    tick       = i_f_ref & ~f_ref_q;
    stuck_rise = i_stuck & ~stuck_q;
    busy_state = (state_q == S_LOW) || (state_q == S_HIGH) || (state_q == S_STOP_A) ||
                 (state_q == S_STOP_B) || (state_q == S_STOP_C);
    state_d = state_q;
    cnt_d   = cnt_q;
    str_d   = str_q;
    pcnt_d  = pcnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_en && stuck_rise) begin
          state_d = S_LOW;
          cnt_d   = T_LOW;
          pcnt_d  = '0;
        end
      end
      S_LOW, S_STOP_A: begin
        if (tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d = (state_q == S_LOW) ? S_HIGH : S_STOP_B;
            cnt_d   = T_HIGH;
            str_d   = T_STR;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      // high phase only counts once SCL is actually seen high; until then the stretch limit runs
      S_HIGH, S_STOP_B: begin
        if (tick) begin
          if (!i_scl) begin
            if (str_q == CNT_ONE) state_d = S_FAIL;
            else                  str_d   = str_q - CNT_ONE;
          end else if (cnt_q != CNT_ONE) begin
            cnt_d = cnt_q - CNT_ONE;
          end else if (state_q == S_STOP_B) begin
            state_d = S_STOP_C;
            cnt_d   = T_IDLE;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
            if (i_sda) begin
              state_d = S_STOP_A;
              cnt_d   = T_LOW;
            end else if (pcnt_d == PULSES) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_LOW;
              cnt_d   = T_LOW;
            end
          end
        end
      end
      S_STOP_C: begin
        if (i_idle) begin
          state_d = S_DONE;
        end else if (tick) begin
          if (cnt_q == CNT_ONE) state_d = S_FAIL;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
      end
      S_DONE:  state_d = S_REARM;
      S_FAIL:  if (!i_stuck) state_d = S_IDLE;
      S_REARM: if (!i_stuck) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (busy_state && !i_en) state_d = S_IDLE;

    scl_pull_d = (state_d == S_LOW) || (state_d == S_STOP_A);
    // SDA is pulled only after SCL has been low for a full cycle
    sda_pull_d = ((state_d == S_STOP_A) && (state_q == S_STOP_A)) || (state_d == S_STOP_B);
    busy_d     = (state_d == S_LOW) || (state_d == S_HIGH) || (state_d == S_STOP_A) ||
                 (state_d == S_STOP_B) || (state_d == S_STOP_C);
    done_d     = (state_d == S_DONE);
    fail_d     = (state_d == S_FAIL);
  end

  // stuck edge register resets high so a stuck level already present at reset is not an edge
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      str_q      <= '0;
      pcnt_q     <= '0;
      f_ref_q    <= 1'b0;
      stuck_q    <= 1'b1;
      scl_pull_q <= 1'b0;
      sda_pull_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      str_q      <= str_d;
      pcnt_q     <= pcnt_d;
      f_ref_q    <= i_f_ref;
      stuck_q    <= i_stuck;
      scl_pull_q <= scl_pull_d;
      sda_pull_q <= sda_pull_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign o_scl_pull = scl_pull_q;
  assign o_sda_pull = sda_pull_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_fail     = fail_q;

endmodule

// File: tb/tb_i2c_passthru_bus_recovery.sv
// Directed bench for i2c_passthru_bus_recovery: open-drain bus model with a target
// holding SDA, optional external SCL hold/stretch, and an idle detector stand-in.
module tb_i2c_passthru_bus_recovery;

  logic clk, rst_n, f_ref, en, stuck, idle;
  logic ext_low, tgt_low;
  logic scl_pull, sda_pull, busy, done, fail;
  wire  scl_bus = !(scl_pull || ext_low);
  wire  sda_bus = !(sda_pull || tgt_low);

  i2c_passthru_bus_recovery dut (
    .i_clk      (clk),
    .i_rstn     (rst_n),
    .i_f_ref    (f_ref),
    .i_en       (en),
    .i_stuck    (stuck),
    .i_idle     (idle),
    .i_scl      (scl_bus),
    .i_sda      (sda_bus),
    .o_scl_pull (scl_pull),
    .o_sda_pull (sda_pull),
    .o_busy     (busy),
    .o_done     (done),
    .o_fail     (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // one f_ref tick every 4 clk cycles
  initial begin
    f_ref = 1'b0;
    forever begin
      repeat (2) @(negedge clk);
      f_ref = ~f_ref;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // bus / target model state, all owned by the main process
  int cyc = 0;
  int scl_rises, scl_falls, sda_rises, viol, stop_seen, done_cnt, fail_rises, busy_cnt;
  int lo_run, hi_run, rel_run, lo_min, lo_max, hi_min, hi_max, rel_max;
  int rel_time, fail_time, idle_cnt, ext_cnt;
  int ext_mode, tgt_rel;
  logic tgt_hold, idle_auto, ext_forever;
  logic p_scl_pull, p_sda_pull, p_fail, p_scl_b, p_sda_b;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    scl_rises = 0; scl_falls = 0; sda_rises = 0; viol = 0; stop_seen = 0;
    done_cnt = 0; fail_rises = 0; busy_cnt = 0;
    lo_run = 0; hi_run = 0; rel_run = 0;
    lo_min = 9999; lo_max = 0; hi_min = 9999; hi_max = 0; rel_max = 0;
    rel_time = -1; fail_time = -1; idle_cnt = 0; ext_cnt = 0;
  endtask

  task automatic step();
    logic scl_b, sda_b;
    @(negedge clk);
    cyc++;
    scl_b = !(scl_pull || ext_low);
    sda_b = !(sda_pull || tgt_low);
    if (p_scl_b && scl_b && p_sda_b && !sda_b) viol++;
    if (p_scl_b && scl_b && !p_sda_b && sda_b) stop_seen++;
    if (scl_pull && !p_scl_pull) begin
      scl_rises++;
      if (hi_run > 0) begin
        if (hi_run < hi_min) hi_min = hi_run;
        if (hi_run > hi_max) hi_max = hi_run;
      end
      if (rel_run > rel_max) rel_max = rel_run;
      hi_run = 0;
      rel_run = 0;
    end
    if (!scl_pull && p_scl_pull) begin
      scl_falls++;
      if (lo_run < lo_min) lo_min = lo_run;
      if (lo_run > lo_max) lo_max = lo_run;
      lo_run = 0;
      if (ext_mode == 1 && scl_falls == 1) begin
        ext_forever = 1'b1;
        rel_time = cyc;
      end
      if (ext_mode == 2 && scl_falls == 2) ext_cnt = 160;
    end
    if (scl_pull) lo_run++;
    if (busy && !scl_pull) rel_run++;
    if (busy && !scl_pull && scl_b) hi_run++;
    if (sda_pull && !p_sda_pull) sda_rises++;
    if (!sda_pull && p_sda_pull && idle_auto) idle_cnt = 8;
    if (idle_cnt > 0) begin
      idle_cnt--;
      if (idle_cnt == 0) idle = 1'b1;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (fail && !p_fail) begin
      fail_rises++;
      fail_time = cyc;
    end
    if (ext_cnt > 0) ext_cnt--;
    ext_low = ext_forever || (ext_cnt > 0);
    tgt_low = tgt_hold && (scl_rises < tgt_rel);
    p_scl_pull = scl_pull;
    p_sda_pull = sda_pull;
    p_fail     = fail;
    p_scl_b    = scl_b;
    p_sda_b    = sda_b;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic quiesce();
    stuck = 1'b0; idle = 1'b0; idle_auto = 1'b0; tgt_hold = 1'b0;
    ext_mode = 0; ext_forever = 1'b0;
    steps(6);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; stuck = 1'b0; idle = 1'b0;
    ext_low = 1'b0; tgt_low = 1'b0; ext_forever = 1'b0; ext_mode = 0;
    tgt_hold = 1'b0; tgt_rel = 0; idle_auto = 1'b0;
    p_scl_pull = 1'b0; p_sda_pull = 1'b0; p_fail = 1'b0; p_scl_b = 1'b1; p_sda_b = 1'b1;
    clear_stats();
    steps(4);
    check("rst_scl_pull", scl_pull, 0);
    check("rst_sda_pull", sda_pull, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    rst_n = 1'b1;
    steps(4);

    // 1: target releases SDA during pulse 3, idle follows the STOP
    tgt_hold = 1'b1; tgt_rel = 3; idle_auto = 1'b1;
    steps(3);
    clear_stats();
    stuck = 1'b1;
    steps(2);
    check("t1_busy_start", busy, 1);
    for (int n = 0; n < 3000 && done_cnt == 0 && fail_rises == 0; n++) step();
    steps(3);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_fail", fail_rises, 0);
    check("t1_scl_pull_rises", scl_rises, 4);
    check("t1_sda_pull_rises", sda_rises, 1);
    check("t1_stop_seen", stop_seen, 1);
    check("t1_false_start", viol, 0);
    check("t1_low_min_ok", (lo_min >= 77 && lo_min <= 80), 1);
    check("t1_low_max", lo_max, 80);
    check("t1_high_min", hi_min, 80);
    check("t1_high_max", hi_max, 80);
    check("t1_busy_end", busy, 0);
    quiesce();

    // 2: SDA stuck forever -> 9 pulses then FAIL
    tgt_hold = 1'b1; tgt_rel = 1000;
    steps(3);
    clear_stats();
    stuck = 1'b1;
    for (int n = 0; n < 3000 && !fail; n++) step();
    check("t2_fail_seen", fail, 1);
    check("t2_pulses", scl_rises, 9);
    check("t2_sda_pull_rises", sda_rises, 0);
    check("t2_stop_seen", stop_seen, 0);
    check("t2_busy", busy, 0);
    steps(50);
    check("t2_fail_held", fail, 1);
    check("t2_pulls_off", scl_pull | sda_pull, 0);
    stuck = 1'b0;
    steps(3);
    check("t2_fail_cleared", fail, 0);
    clear_stats();
    stuck = 1'b1;
    steps(3);
    check("t2_restart_busy", busy, 1);

    // 5: enable dropped in the LOW of pulse 4
    for (int n = 0; n < 2000 && scl_rises < 4; n++) step();
    steps(10);
    check("t5_mid_low", scl_pull, 1);
    en = 1'b0;
    step();
    check("t5_scl_released", scl_pull, 0);
    check("t5_sda_released", sda_pull, 0);
    check("t5_busy", busy, 0);
    clear_stats();
    step();
    en = 1'b1;
    steps(1000);
    check("t5_no_retrigger", busy_cnt, 0);
    check("t5_no_done", done_cnt, 0);
    check("t5_no_fail", fail_rises, 0);
    quiesce();

    // 3: SCL held low externally after the first release -> stretch limit
    clear_stats();
    ext_mode = 1;
    stuck = 1'b1;
    for (int n = 0; n < 2000 && !fail; n++) step();
    check("t3_fail_seen", fail, 1);
    check("t3_fail_delay", fail_time - rel_time, 800);
    check("t3_scl_pull", scl_pull, 0);
    check("t3_sda_pull", sda_pull, 0);
    check("t3_pulses", scl_rises, 1);
    quiesce();

    // 4: SCL stretched 160 cycles in pulse 2, SDA released in pulse 3
    tgt_hold = 1'b1; tgt_rel = 3; idle_auto = 1'b1;
    steps(3);
    clear_stats();
    ext_mode = 2;
    stuck = 1'b1;
    for (int n = 0; n < 3000 && done_cnt == 0 && fail_rises == 0; n++) step();
    steps(3);
    check("t4_done_pulses", done_cnt, 1);
    check("t4_fail", fail_rises, 0);
    check("t4_scl_pull_rises", scl_rises, 4);
    check("t4_high_min_ok", (hi_min >= 77 && hi_min <= 81), 1);
    check("t4_high_max_ok", (hi_max >= 77 && hi_max <= 81), 1);
    check("t4_stretched_release_ok", (rel_max >= 236 && rel_max <= 242), 1);
    check("t4_false_start", viol, 0);
    quiesce();

    // 6: async reset during STOP_A
    tgt_hold = 1'b1; tgt_rel = 1; idle_auto = 1'b1;
    steps(3);
    clear_stats();
    stuck = 1'b1;
    for (int n = 0; n < 1000 && !(scl_pull && sda_pull); n++) step();
    check("t6_in_stop_a", scl_pull & sda_pull, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_scl_pull", scl_pull, 0);
    check("t6_rst_sda_pull", sda_pull, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_fail", fail, 0);
    step();
    rst_n = 1'b1;
    clear_stats();
    steps(500);
    check("t6_no_start_after_reset", busy_cnt, 0);
    stuck = 1'b0;
    steps(3);
    stuck = 1'b1;
    steps(3);
    check("t6_restart_busy", busy, 1);
    quiesce();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
